// File: rtl/lcd_ctrl_param_if.sv
// Host-side write port and status/LCD pins of the character LCD controller.
// The controller takes the slave modport; the host or driver takes the master one.
interface lcd_ctrl_param_if #(
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              refresh_req;
    logic              init_done;
    logic              busy;
    logic [3:0]        dataout;
    logic [2:0]        control;

    modport master (
        output wr_en, wr_addr, wr_data, refresh_req,
        input  init_done, busy, dataout, control
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, refresh_req,
        output init_done, busy, dataout, control
    );
endinterface

// File: rtl/lcd_ctrl_param.sv
// HD44780-style 4-bit LCD controller: power-on init, config, then mirrors a ROWS x COLS buffer.
// Define LCD_CGRAM_LOAD_EN to load a custom glyph 0 into CGRAM before init_done.
module lcd_ctrl_param #(
    parameter int COLS         = 16,
    parameter int ROWS         = 2,
    parameter int T_POR        = 750000,
    parameter int T_INIT_LONG  = 205000,
    parameter int T_INIT_SHORT = 2000,
    parameter int T_SETUP      = 2,
    parameter int T_E          = 12,
    parameter int T_NIB        = 50,
    parameter int T_CMD        = 2000,
    parameter int T_CLR        = 82000
) (
    input  logic             clk,
    input  logic             rst,
    lcd_ctrl_param_if.slave  bus
);
    localparam int N      = ROWS * COLS;
    localparam int ADDR_W = $clog2(N);
    localparam int COL_W  = $clog2(COLS);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POR, T_INIT_LONG), max2(T_INIT_SHORT, T_SETUP)),
                                max2(max2(T_E, T_NIB), max2(T_CMD, T_CLR)));
    localparam int CNT_W = ($clog2(T_MAX + 1) > 20) ? $clog2(T_MAX + 1) : 20;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [3:0] {
        S_POR, S_INIT, S_CFG, S_CGRAM, S_IDLE, S_SETADDR, S_DATA, S_NEXTROW
    } state_t;

    // Sub-phases of one nibble/byte transfer on the LCD bus.
    typedef enum logic [2:0] {
        P_IDLE, P_SETUP, P_E, P_HOLD, P_GAP, P_WAIT
    } phase_t;

    localparam logic [ADDR_W:0] N_W = (ADDR_W + 1)'(N);

    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

`ifdef LCD_CGRAM_LOAD_EN
    function automatic logic [7:0] glyph(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h0C;
            3'd1:    return 8'h0E;
            3'd2:    return 8'h04;
            3'd3:    return 8'h1F;
            3'd4:    return 8'h04;
            3'd5:    return 8'h0A;
            3'd6:    return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction
`endif

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    cnt_t              cnt_q, cnt_d;
    logic [3:0]        step_q, step_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]        byte_q, byte_d;
    logic              rs_q, rs_d;
    logic              lo_q, lo_d;
    logic              single_q, single_d;
    logic              dirty_q, dirty_d;
    logic              init_done_q, init_done_d;
    logic [7:0]        buf_q [N];

    logic       wr_ok;
    logic       done;
    logic       launch, l_rs, l_single, l_data;
    logic [7:0] l_byte;
    cnt_t       wait_len;

    assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < N_W);

    // NOTE: every variable gets a default before the case logic so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        col_d       = col_q;
        row_d       = row_q;
        rd_idx_d    = rd_idx_q;
        byte_d      = byte_q;
        rs_d        = rs_q;
        lo_d        = lo_q;
        single_d    = single_q;
        dirty_d     = dirty_q;
        init_done_d = init_done_q;
        done        = 1'b0;
        launch      = 1'b0;
        l_rs        = 1'b0;
        l_single    = 1'b0;
        l_data      = 1'b0;
        l_byte      = 8'h00;

        if (single_q)
            wait_len = (step_q < 4'd2) ? cnt_t'(T_INIT_LONG - 1) : cnt_t'(T_INIT_SHORT - 1);
        else
            wait_len = (byte_q == 8'h01 && !rs_q) ? cnt_t'(T_CLR - 1) : cnt_t'(T_CMD - 1);

        if (cnt_q != '0) begin
            if (phase_q != P_IDLE || state_q == S_POR)
                cnt_d = cnt_q - 1'b1;
        end else begin
            case (phase_q)
                P_SETUP: begin phase_d = P_E;    cnt_d = cnt_t'(T_E - 1);     end
                P_E:     begin phase_d = P_HOLD; cnt_d = cnt_t'(T_SETUP - 1); end
                P_HOLD: begin
                    if (single_q || lo_q) begin
                        phase_d = P_WAIT;
                        cnt_d   = wait_len;
                    end else begin
                        phase_d = P_GAP;
                        cnt_d   = cnt_t'(T_NIB - 1);
                    end
                end
                P_GAP:   begin phase_d = P_SETUP; lo_d = 1'b1; cnt_d = cnt_t'(T_SETUP - 1); end
                P_WAIT:  begin phase_d = P_IDLE;  done = 1'b1; end
                default: ;
            endcase
        end

        case (state_q)
            S_POR: begin
                if (cnt_q == '0) begin
                    state_d  = S_INIT;
                    step_d   = 4'd0;
                    launch   = 1'b1;
                    l_single = 1'b1;
                    l_byte   = 8'h30;
                end
            end
            S_INIT: begin
                if (done) begin
                    launch = 1'b1;
                    if (step_q == 4'd3) begin
                        state_d = S_CFG;
                        step_d  = 4'd0;
                        l_byte  = cfg_byte(2'd0);
                    end else begin
                        step_d   = step_q + 4'd1;
                        l_single = 1'b1;
                        l_byte   = (step_q == 4'd2) ? 8'h20 : 8'h30;
                    end
                end
            end
            S_CFG: begin
                if (done) begin
                    if (step_q == 4'd3) begin
`ifdef LCD_CGRAM_LOAD_EN
                        state_d = S_CGRAM;
                        step_d  = 4'd0;
                        launch  = 1'b1;
                        l_byte  = 8'h40;
`else
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
`endif
                    end else begin
                        step_d = step_q + 4'd1;
                        launch = 1'b1;
                        l_byte = cfg_byte(step_q[1:0] + 2'd1);
                    end
                end
            end
`ifdef LCD_CGRAM_LOAD_EN
            S_CGRAM: begin
                if (done) begin
                    if (step_q == 4'd8) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        step_d = step_q + 4'd1;
                        launch = 1'b1;
                        l_rs   = 1'b1;
                        l_byte = glyph(step_q[2:0]);
                    end
                end
            end
`endif
            S_IDLE: begin
                if (dirty_q || bus.refresh_req) begin
                    state_d  = S_SETADDR;
                    dirty_d  = 1'b0;
                    row_d    = 2'd0;
                    col_d    = '0;
                    rd_idx_d = '0;
                    launch   = 1'b1;
                    l_byte   = 8'h80;
                end
            end
            S_SETADDR: begin
                if (done) begin
                    state_d = S_DATA;
                    launch  = 1'b1;
                    l_data  = 1'b1;
                end
            end
            S_DATA: begin
                if (done) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == 2'(ROWS - 1)) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_NEXTROW;
                            row_d   = row_q + 2'd1;
                        end
                    end else begin
                        col_d  = col_q + 1'b1;
                        launch = 1'b1;
                        l_data = 1'b1;
                    end
                end
            end
            S_NEXTROW: begin
                state_d = S_SETADDR;
                launch  = 1'b1;
                l_byte  = 8'h80 | row_base(row_q);
            end
            default: state_d = S_POR;
        endcase

        if (state_q != S_IDLE && bus.refresh_req)
            dirty_d = 1'b1;
        if (wr_ok)
            dirty_d = 1'b1;

        // Characters are sampled from the buffer at the start of their own byte write.
        if (launch) begin
            phase_d  = P_SETUP;
            cnt_d    = cnt_t'(T_SETUP - 1);
            lo_d     = 1'b0;
            single_d = l_single;
            rs_d     = l_rs || l_data;
            byte_d   = l_data ? buf_q[rd_idx_d] : l_byte;
        end
    end

    // NOTE: the character buffer is reset explicitly because the panel must show spaces after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_POR;
            phase_q     <= P_IDLE;
            cnt_q       <= cnt_t'(T_POR - 1);
            step_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rd_idx_q    <= '0;
            byte_q      <= '0;
            rs_q        <= 1'b0;
            lo_q        <= 1'b0;
            single_q    <= 1'b0;
            dirty_q     <= 1'b1;
            init_done_q <= 1'b0;
            for (int i = 0; i < N; i++)
                buf_q[i] <= 8'h20;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rd_idx_q    <= rd_idx_d;
            byte_q      <= byte_d;
            rs_q        <= rs_d;
            lo_q        <= lo_d;
            single_q    <= single_d;
            dirty_q     <= dirty_d;
            init_done_q <= init_done_d;
            if (wr_ok)
                buf_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    logic drive;
    assign drive         = (phase_q == P_SETUP) || (phase_q == P_E) || (phase_q == P_HOLD);
    assign bus.dataout   = drive ? (lo_q ? byte_q[3:0] : byte_q[7:4]) : 4'h0;
    assign bus.control   = {phase_q == P_E, drive && rs_q, 1'b0};
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Scoreboard bench for lcd_ctrl_param: decodes the 4-bit LCD stream and compares it
// against the expected init/config/refresh byte sequence.
module tb_lcd_ctrl_param;
    localparam int COLS = 16;
    localparam int ROWS = 2;
    localparam int TP   = 10;
    localparam int TS   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_ctrl_param_if #(.ADDR_W(5)) bus ();
    lcd_ctrl_param_if #(.ADDR_W(6)) bus2 ();

    lcd_ctrl_param #(
        .COLS(COLS), .ROWS(ROWS), .T_POR(TP), .T_INIT_LONG(TS), .T_INIT_SHORT(TS),
        .T_SETUP(TS), .T_E(TS), .T_NIB(TS), .T_CMD(TS), .T_CLR(TS)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    // Non-power-of-two buffer so that out-of-range addresses are representable.
    lcd_ctrl_param #(
        .COLS(20), .ROWS(2), .T_POR(TP), .T_INIT_LONG(TS), .T_INIT_SHORT(TS),
        .T_SETUP(TS), .T_E(TS), .T_NIB(TS), .T_CMD(TS), .T_CLR(TS)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q [$];
    logic [7:0] mbuf [ROWS*COLS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROWS*COLS; i++) mbuf[i] = 8'h20;
    endtask

    task automatic push_init();
        exp_q.push_back(9'h003); exp_q.push_back(9'h003);
        exp_q.push_back(9'h003); exp_q.push_back(9'h002);
        exp_q.push_back(9'h028); exp_q.push_back(9'h006);
        exp_q.push_back(9'h00C); exp_q.push_back(9'h001);
`ifdef LCD_CGRAM_LOAD_EN
        exp_q.push_back(9'h040);
        exp_q.push_back(9'h10C); exp_q.push_back(9'h10E); exp_q.push_back(9'h104);
        exp_q.push_back(9'h11F); exp_q.push_back(9'h104); exp_q.push_back(9'h10A);
        exp_q.push_back(9'h11B); exp_q.push_back(9'h100);
`endif
    endtask

    task automatic push_refresh();
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back({1'b0, (r == 0) ? 8'h80 : 8'hC0});
            for (int c = 0; c < COLS; c++)
                exp_q.push_back({1'b1, mbuf[r*COLS + c]});
        end
    endtask

    // Bus monitor: one nibble per rising E; the first four after reset are single init nibbles.
    initial begin
        logic       prev_e;
        int         nib_cnt;
        logic       have_hi;
        logic [3:0] hi_nib;
        logic       hi_rs;
        logic [8:0] obs;
        prev_e = 1'b0; nib_cnt = 0; have_hi = 1'b0; hi_nib = '0; hi_rs = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_e = 1'b0; nib_cnt = 0; have_hi = 1'b0;
            end else begin
                if (bus.control[2] && !prev_e) begin
                    check("rw", bus.control[0], 1'b0);
                    if (nib_cnt < 4 || have_hi) begin
                        obs = (nib_cnt < 4) ? {bus.control[1], 4'h0, bus.dataout}
                                            : {hi_rs, hi_nib, bus.dataout};
                        if (nib_cnt < 4) nib_cnt++;
                        have_hi = 1'b0;
                        if (exp_q.size() == 0)
                            check("unexpected_byte", obs, 'x);
                        else
                            check("lcd_byte", obs, exp_q.pop_front());
                    end else begin
                        have_hi = 1'b1;
                        hi_nib  = bus.dataout;
                        hi_rs   = bus.control[1];
                    end
                end
                prev_e = bus.control[2];
            end
        end
    end

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        bus.refresh_req = 1'b1;
        @(negedge clk);
        bus.refresh_req = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!bus.busy && n < 10) begin @(negedge clk); n++; end
        check(tag, bus.busy, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(bus.busy == 1'b0 && exp_q.size() == 0) && n < budget) begin
            @(negedge clk); n++;
        end
        check(tag, (n < budget), 1'b1);
        check({tag, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.refresh_req = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.refresh_req = 1'b0;

        // Reset state
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_control", bus.control, 3'b000);
        check("rst_dataout", bus.dataout, 4'h0);
        check("rst_busy", bus.busy, 1'b1);
        check("rst_init_done", bus.init_done, 1'b0);
        model_reset();
        push_init();
        push_refresh();
        rst = 1'b0;

        // POR length, then setup before the first E pulse
        n = 0;
        while (bus.dataout != 4'h3 && n < 100) begin @(negedge clk); n++; end
        check("por_cycles", n, TP);
        n = 0;
        while (!bus.control[2] && n < 100) begin @(negedge clk); n++; end
        check("setup_cycles", n, TS);
        check("first_nibble", bus.dataout, 4'h3);

        wait_idle("init", 5000);
        check("init_done", bus.init_done, 1'b1);

        // Single write in IDLE
        mbuf[0] = 8'h41;
        push_refresh();
        host_write(5'd0, 8'h41);
        wait_busy("start_w0");
        wait_idle("refresh_w0", 3000);

        // Row-1 entry
        mbuf[16] = 8'h24;
        push_refresh();
        host_write(5'd16, 8'h24);
        wait_busy("start_w16");
        wait_idle("refresh_w16", 3000);
        check("idle_control", bus.control, 3'b000);

        // Write during a refresh: lands in the current pass and forces a second one
        mbuf[31] = 8'h77;
        push_refresh();
        push_refresh();
        pulse_refresh();
        wait_busy("start_req");
        host_write(5'd31, 8'h77);
        wait_idle("double_refresh", 6000);

        // Out-of-range write on the 40-entry instance
        check("dut2_idle", bus2.busy, 1'b0);
        @(negedge clk);
        bus2.wr_en = 1'b1; bus2.wr_addr = 6'd45; bus2.wr_data = 8'h41;
        @(negedge clk);
        bus2.wr_en = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus2.busy) n++;
        end
        check("oob_no_refresh", n, 0);
        bus2.wr_en = 1'b1; bus2.wr_addr = 6'd39; bus2.wr_data = 8'h41;
        @(negedge clk);
        bus2.wr_en = 1'b0;
        n = 0;
        while (!bus2.busy && n < 10) begin @(negedge clk); n++; end
        check("inrange_refresh", bus2.busy, 1'b1);

        // Reset during a data E pulse
        push_refresh();
        pulse_refresh();
        n = 0;
        while (bus.control != 3'b110 && n < 300) begin @(negedge clk); n++; end
        check("data_e_seen", bus.control, 3'b110);
        rst = 1'b1;
        @(negedge clk);
        check("rst_e_drop", bus.control[2], 1'b0);
        check("rst2_busy", bus.busy, 1'b1);
        check("rst2_init_done", bus.init_done, 1'b0);
        exp_q.delete();
        model_reset();
        push_init();
        push_refresh();
        rst = 1'b0;
        wait_idle("reinit", 5000);
        check("reinit_done", bus.init_done, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
